// File: rtl/pkg_ram.sv
// Shared memory-side widths for the device pipes.
`timescale 1ns/1ps
package pkg_ram;
  localparam int unsigned RAM_BYTE = 8;
endpackage

// File: rtl/pkg_uart.sv
// Serial frame constants and receiver state encoding.
`timescale 1ns/1ps
package pkg_uart;
  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned BIT_IDX_W = $clog2(DATA_BITS);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, one-cycle rx_valid pulse.
// rx_frame_err accompanies rx_valid when the stop bit was sampled low.
`timescale 1ns/1ps
module uart_rx
  import pkg_ram::*;
  import pkg_uart::*;
#(
  parameter int unsigned CLK_FREQ = 12_000_000,
  parameter int unsigned BAUD     = 9_600
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  output logic [RAM_BYTE-1:0] rx_data,
  output logic                rx_valid,
  output logic                rx_frame_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned HALF_M1      = (CLKS_PER_BIT >= 2) ? (CLKS_PER_BIT / 2 - 1) : 0;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_M1);

  rx_state_t              state_q, state_d;
  logic [1:0]             sync_q;
  logic                   rx_s;
  logic                   rx_prev_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_IDX_W-1:0]   bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   valid_q, valid_d;
  logic                   ferr_q, ferr_d;

  assign rx_s = sync_q[1];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_prev_q && !rx_s) state_d = START;
      end
      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_q == BIT_IDX_W'(DATA_BITS - 1)) state_d = STOP;
          else                                     bit_d   = bit_q + BIT_IDX_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output decode: report the byte at the stop-bit sample
  always_comb begin
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if (state_q == STOP && cnt_q == CNT_FULL) begin
      valid_d = 1'b1;
      ferr_d  = !rx_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], rx};
      rx_prev_q <= rx_s;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign rx_data      = RAM_BYTE'(shift_q);
  assign rx_valid     = valid_q;
  assign rx_frame_err = ferr_q;

endmodule

// File: rtl/dev_rx_pipe.sv
// Receive pipe: uart_rx feeding a first-word-fall-through circular FIFO with sticky flags.
// Define DEV_RX_PIPE_FRAME_CHECK_EN to drop bad-stop-bit bytes and raise frame_err.
`timescale 1ns/1ps
module dev_rx_pipe
  import pkg_ram::*;
#(
  parameter int unsigned CLK_FREQ = 12_000_000,
  parameter int unsigned BAUD     = 9_600,
  parameter int unsigned DEPTH    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx,
  input  logic                pop_front,
  output logic [RAM_BYTE-1:0] data_out,
  output logic                empty,
  output logic                overflow,
  output logic                frame_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [RAM_BYTE-1:0] rx_data;
  logic                rx_valid;
  logic                rx_frame_err;
  logic                accept;
  logic                ferr_set;

  logic [RAM_BYTE-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]    rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                empty_q, overflow_q, frame_err_q;
  logic                full, do_push, do_pop, drop;

  uart_rx #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_rx (
    .clk          (clk),
    .rst          (rst),
    .rx           (rx),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_frame_err (rx_frame_err)
  );

`ifdef DEV_RX_PIPE_FRAME_CHECK_EN
  assign accept   = rx_valid && !rx_frame_err;
  assign ferr_set = rx_valid && rx_frame_err;
`else
  logic unused_frame_err;
  assign unused_frame_err = rx_frame_err;
  assign accept           = rx_valid;
  assign ferr_set         = 1'b0;
`endif

  // A push into a full FIFO is allowed only when the head leaves in the same cycle
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_front && !empty_q;
  assign do_push = accept && (!full || pop_front);
  assign drop    = accept && full && !pop_front;

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      empty_q <= (count_d == '0);
      if (drop)     overflow_q  <= 1'b1;
      if (ferr_set) frame_err_q <= 1'b1;
    end
  end

  // Storage needs no reset; validity is tracked by count
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= rx_data;
  end

  assign data_out  = mem_q[rd_ptr_q];
  assign empty     = empty_q;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_dev_rx_pipe.sv
// Scoreboard bench for dev_rx_pipe: serial stimulus with a queue model of the FIFO and flags.
`timescale 1ns/1ps
module tb_dev_rx_pipe;

  localparam int unsigned CLK_FREQ = 160_000;
  localparam int unsigned BAUD     = 10_000;
  localparam int unsigned DEPTH    = 4;
  localparam int unsigned CPB      = CLK_FREQ / BAUD;
`ifdef DEV_RX_PIPE_FRAME_CHECK_EN
  localparam bit FCHK = 1'b1;
`else
  localparam bit FCHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       pop_front = 1'b0;
  logic [7:0] data_out;
  logic       empty, overflow, frame_err;

  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] exp_q[$];
  bit         ovf_exp = 1'b0;
  bit         ferr_exp = 1'b0;

  always #5 clk = ~clk;

  dev_rx_pipe #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD),
    .DEPTH    (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .pop_front (pop_front),
    .data_out  (data_out),
    .empty     (empty),
    .overflow  (overflow),
    .frame_err (frame_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    pop_front = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    ovf_exp = 1'b0;
    ferr_exp = 1'b0;
  endtask

  // Model: a frame lands in the FIFO unless rejected by the stop check or the FIFO is full
  task automatic send_byte(input logic [7:0] b, input bit stop_bit, input bit pop_on_push);
    bit accepted;
    bit popped;
    accepted = stop_bit || !FCHK;
    if (!accepted) ferr_exp = 1'b1;
    else if (exp_q.size() < DEPTH || pop_on_push) exp_q.push_back(b);
    else ovf_exp = 1'b1;

    @(negedge clk);
    rx = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      cycles(CPB);
    end
    rx = stop_bit;
    popped = 1'b0;
    for (int i = 0; i < int'(CPB); i++) begin
      @(negedge clk);
      if (pop_on_push && !popped && dut.rx_valid) begin
        pop_front = 1'b1;
        popped = 1'b1;
      end else begin
        pop_front = 1'b0;
      end
    end
    rx = 1'b1;
    cycles(4);
    if (pop_on_push) check("pop_with_push_window", 32'(popped), 32'd1);
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 4 * DEPTH + 8;
    @(negedge clk);
    pop_front = 1'b1;
    while (exp_q.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    pop_front = 1'b0;
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({name, "_empty"}, 32'(empty), 32'd1);
  endtask

  // Monitor: every accepted pop is compared with the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && pop_front && !empty) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_pop: got 0x%0h, want no byte", data_out);
        end else begin
          check("pop_data", 32'(data_out), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] trio [3];
    logic [7:0] b;
    logic [7:0] pat;
    trio[0] = 8'h00;
    trio[1] = 8'hFF;
    trio[2] = 8'hA5;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset_empty", 32'(empty), 32'd1);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);

    send_byte(8'h41, 1'b1, 1'b0);
    check("single_nonempty", 32'(empty), 32'd0);
    check("single_data", 32'(data_out), 32'h41);
    drain("single");

    for (int i = 0; i < 3; i++) send_byte(trio[i], 1'b1, 1'b0);
    drain("trio");

    @(negedge clk);
    rx = 1'b0;
    cycles(5);
    rx = 1'b1;
    cycles(3 * CPB);
    check("glitch_empty", 32'(empty), 32'd1);
    send_byte(8'h5A, 1'b1, 1'b0);
    drain("after_glitch");

    for (int i = 0; i < int'(DEPTH) + 1; i++) send_byte(8'($urandom), 1'b1, 1'b0);
    check("overflow_set", 32'(overflow), 32'(ovf_exp));
    drain("overflow");

    do_reset();
    for (int i = 0; i < int'(DEPTH); i++) send_byte(8'($urandom), 1'b1, 1'b0);
    send_byte(8'($urandom), 1'b1, 1'b1);
    check("pop_push_overflow", 32'(overflow), 32'(ovf_exp));
    check("pop_push_nonempty", 32'(empty), 32'd0);
    drain("pop_push");

    send_byte(8'h3C, 1'b0, 1'b0);
    check("frame_err", 32'(frame_err), 32'(ferr_exp));
    check("frame_empty", 32'(empty), 32'(exp_q.size() == 0));
    drain("frame");

    // Abort a 0x55 frame mid-data with a one-cycle reset
    pat = 8'h55;
    @(negedge clk);
    rx = 1'b0;
    cycles(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = pat[i];
      cycles(CPB);
    end
    rx = 1'b1;
    do_reset();
    cycles(2 * CPB);
    check("midrst_empty", 32'(empty), 32'd1);
    send_byte(8'h12, 1'b1, 1'b0);
    check("midrst_overflow", 32'(overflow), 32'd0);
    check("midrst_frame_err", 32'(frame_err), 32'd0);
    drain("midrst");

    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom);
      send_byte(b, 1'b1, 1'b0);
      if ($urandom_range(0, 2) == 0) drain("rand");
    end
    check("rand_overflow", 32'(overflow), 32'(ovf_exp));
    check("rand_frame_err", 32'(frame_err), 32'(ferr_exp));
    drain("rand_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
